// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - character codes and segment glyph table shared by the scanner and marquee shifter
package seg7_pkg;

  localparam int CODE_W = 5;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CH_A      = 5'd0;
  localparam code_t CH_B      = 5'd1;
  localparam code_t CH_E      = 5'd2;
  localparam code_t CH_F      = 5'd3;
  localparam code_t CH_G      = 5'd4;
  localparam code_t CH_H      = 5'd5;
  localparam code_t CH_I      = 5'd6;
  localparam code_t CH_J      = 5'd7;
  localparam code_t CH_L      = 5'd8;
  localparam code_t CH_P      = 5'd9;
  localparam code_t CH_S      = 5'd10;
  localparam code_t CH_T      = 5'd11;
  localparam code_t CH_O      = 5'd12;
  localparam code_t CH_N      = 5'd13;
  localparam code_t CH_R      = 5'd14;
  localparam code_t CH_BLANK  = 5'd15;
  localparam code_t CH_Y      = 5'd16;
  localparam code_t CH_U      = 5'd17;
  localparam code_t CH_DIGIT0 = 5'd18;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}; dp stays dark everywhere.
  function automatic logic [7:0] seg_of(input code_t code);
    logic [7:0] s;
    case (code)
      CH_A:        s = 8'h88;
      CH_B:        s = 8'h83;
      CH_E:        s = 8'h86;
      CH_F:        s = 8'h8E;
      CH_G:        s = 8'hC2;
      CH_H:        s = 8'h89;
      CH_I:        s = 8'hF9;
      CH_J:        s = 8'hE1;
      CH_L:        s = 8'hC7;
      CH_P:        s = 8'h8C;
      CH_S:        s = 8'h92;
      CH_T:        s = 8'h87;
      CH_O:        s = 8'hC0;
      CH_N:        s = 8'hAB;
      CH_R:        s = 8'hAF;
      CH_BLANK:    s = SEG_OFF;
      CH_Y:        s = 8'h91;
      CH_U:        s = 8'hC1;
      CH_DIGIT0:   s = 8'hC0;
      5'd19:       s = 8'hF9;
      5'd20:       s = 8'hA4;
      5'd21:       s = 8'hB0;
      5'd22:       s = 8'h99;
      5'd23:       s = 8'h92;
      5'd24:       s = 8'h82;
      5'd25:       s = 8'hF8;
      5'd26:       s = 8'h80;
      5'd27:       s = 8'h90;
      default:     s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational character code to active-low segment decode
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [7:0]        seg
);

  assign seg = seg_of(code);

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - four-digit multiplexed seven-segment scanner with dead time and frame latch
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 25000,
  parameter int DEAD     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CODE_W-1:0] q0,
  input  logic [CODE_W-1:0] q1,
  input  logic [CODE_W-1:0] q2,
  input  logic [CODE_W-1:0] q3,
  output logic [3:0]        an,
  output logic [7:0]        seg
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] DEAD_CYC = 16'(DEAD);

  logic [15:0]      cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  code_t [3:0]      code_q, code_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             latch;
  code_t            show_code;
  logic [7:0]       show_seg;

  // In the latch cycle the stored codes are still from the previous frame,
  // so the incoming q0 is decoded directly.
  assign latch     = en && (cnt_q == 16'd0) && (idx_q == 2'd0);
  assign show_code = latch ? q0 : code_q[idx_q];

  seg7_decode u_decode (
    .code (show_code),
    .seg  (show_seg)
  );

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    code_d = code_q;
    an_d   = AN_OFF;
    seg_d  = SEG_OFF;
    if (en) begin
      if (latch) begin
        code_d = {q3, q2, q1, q0};
      end
      if (cnt_q == CNT_LAST) begin
        cnt_d = 16'd0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      if (cnt_q >= DEAD_CYC) begin
        an_d[2'd3 - idx_q] = 1'b0;
      end
      seg_d = show_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 16'd0;
      idx_q  <= 2'd0;
      code_q <= {4{CH_BLANK}};
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      code_q <= code_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter SCAN_DIV, default 25000, clk cycles each digit is scanned; legal range 4..65535.
REQ-002 Parameter DEAD, default 2, anode-off cycles at the start of each digit slot; legal range 1..SCAN_DIV-2.
REQ-003 clk  input  1  single global clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  scan enable; 0 blanks the display and freezes the scan.
REQ-006 q0  input  5  character code, leftmost digit.
REQ-007 q1  input  5  character code, digit 1.
REQ-008 q2  input  5  character code, digit 2.
REQ-009 q3  input  5  character code, rightmost digit.
REQ-010 an  output  4  digit anodes, active-low; an[3] is the leftmost digit (q0) and an[0] is the rightmost digit (q3).
REQ-011 seg  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}; dp is always 1.

Function
REQ-012 Slot counter cnt SHALL count 0..SCAN_DIV-1 while en=1, then wrap to 0; on wrap, digit index idx SHALL advance 0->1->2->3->0.
REQ-013 Frame latch: in any cycle with en=1, cnt=0 and idx=0, the four latched codes SHALL load q0..q3; no other cycle alters them, so a frame is never torn by marquee shifts.
REQ-014 Outputs are registered, one-cycle latency: in cycle t+1, an and seg reflect cnt, idx and the codes of cycle t.
REQ-015 an SHALL be 4'b1111 when cnt<DEAD; otherwise only bit (3-idx) SHALL be 0.
REQ-016 seg SHALL be the decode of latched code[idx]; in the latch cycle it SHALL decode the incoming q0 directly, so no stale glyph is shown.
REQ-017 Decode table: 0 A=88, 1 b=83, 2 E=86, 3 F=8E, 4 G=C2, 5 H=89, 6 I=F9, 7 J=E1, 8 L=C7, 9 P=8C, 10 S=92, 11 t=87, 12 O=C0, 13 n=AB, 14 r=AF, 15 blank=FF, 16 Y=91, 17 U=C1, 18..27 digits 0..9 (C0,F9,A4,B0,99,92,82,F8,80,90), 28..31 blank=FF (hex).
REQ-018 en=0: cnt, idx and the latched codes SHALL hold; the next cycle SHALL drive an=4'b1111 and seg=8'hFF.
REQ-019 On en 0->1, scanning SHALL resume from the held cnt and idx with no skipped or repeated slot.
REQ-020 q0..q3 may change on any cycle; changes become visible only at the next frame latch.

Reset
REQ-021 rst=1 at a clock edge SHALL set cnt=0, idx=0, all latched codes=15, an=4'b1111 and seg=8'hFF, overriding en.
REQ-022 The first cycle with rst=0 and en=1 SHALL be a frame-latch cycle (cnt=0, idx=0).
REQ-023 Reset asserted mid-frame SHALL abandon the frame; no partial-frame state survives.

Structure
REQ-024 Character code constants (A=0 ... blank=15, Y=16, U=17, digit base=18), the 5-bit code width and the segment table SHALL live in the shared package seg7_pkg, which the marquee shifter also uses.
REQ-025 The combinational code-to-segment decode SHALL be a sub-module, seg7_decode (5-bit code in, 8-bit seg out); cnt, idx, latches and output registers stay in seg7_scan.

Verification (SCAN_DIV=4, DEAD=1 unless noted)
REQ-026 Reset, then rst=0, en=1, q0..q3=10,2,2,15 -> cycle 2: an=1111, seg=92; cycles 3-5: an=0111, seg=92; slots 2-4 each 1 dead cycle + 3 lit cycles, with an=1011/seg=86, an=1101/seg=86, an=1110/seg=FF.
REQ-027 Change q0 from 10 to 16 mid-frame -> the current frame still shows 92 on an[3]; the next frame shows 91.
REQ-028 Drop en for 7 cycles in slot idx=2 at cnt=2 -> an=1111 and seg=FF throughout; after en returns, slot 2 finishes its last cycle, then idx=3.
REQ-029 Assert rst at idx=3, cnt=2 -> next cycle an=1111, seg=FF; after release the frame restarts at idx=0 and re-latches the inputs.
REQ-030 Sweep codes 0..31 on q0 over 32 frames -> seg on an[3] matches REQ-017 for every code; codes 28..31 give FF.
REQ-031 Default parameters -> each digit is lit 24998 of every 25000 cycles and the refresh period is 100000 cycles.
